// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the CPU-side memory controller: access sizes, FSM
// states, requester identity and the HCI IO window base.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  typedef enum logic {
    PORT_IF,
    PORT_LS
  } port_t;

  localparam logic [31:0] IO_BASE           = 32'h0003_0000;
  localparam logic [31:0] IDLE_ADDR_DEFAULT = 32'h0000_0000;

  // Size code 3 is treated as a word, like code 2.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-side request/response bundle of the memory controller: the
// instruction-fetch port, the load/store port and the fetch flush.
interface mem_ctrl_if #(
  parameter int unsigned ADDR_WIDTH = 32
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_done;
  logic [31:0]           if_data;
  logic                  flush;

  logic                  ls_req;
  logic                  ls_wr;
  logic [1:0]            ls_size;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic                  ls_done;
  logic [31:0]           ls_rdata;

  modport master (
    output if_req, if_addr, flush, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
    input  if_done, if_data, ls_done, ls_rdata
  );

  modport slave (
    input  if_req, if_addr, flush, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
    output if_done, if_data, ls_done, ls_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Arbitrates fetch vs load/store and serialises 1/2/4-byte little-endian
// accesses onto the byte-wide memory bus, pausing whenever rdy is low.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] IDLE_ADDR  = ADDR_WIDTH'(IDLE_ADDR_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  mem_ctrl_if.slave             bus
);

  state_t                state;
  port_t                 port;
  logic [ADDR_WIDTH-1:0] base;
  logic [2:0]            n;
  logic [31:0]           wdata;
  logic [31:0]           buffer;
  logic [2:0]            cnt;
  logic [2:0]            iss;
  logic                  issuing;
  logic                  pend;
  logic                  wr_q;

  logic [2:0]            cnt_inc;
  logic [2:0]            iss_inc;
  logic [2:0]            last;
  logic [31:0]           rd_word;
  logic                  flush_hit;

  // The write strobe is cut by rdy so the bus never sees a write while HCI owns it.
  assign mem_wr = wr_q & rdy;

  always_comb begin
    cnt_inc = cnt + 3'd1;
    iss_inc = iss + 3'd1;
    last    = n - 3'd1;
    rd_word = buffer;
    rd_word[{cnt[1:0], 3'b000} +: 8] = mem_din;
    flush_hit = bus.flush &&
                ((state == S_READ && port == PORT_IF) ||
                 (state == S_IDLE && bus.if_req && !bus.ls_req));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      port        <= PORT_IF;
      base        <= '0;
      n           <= '0;
      wdata       <= '0;
      buffer      <= '0;
      cnt         <= '0;
      iss         <= '0;
      issuing     <= 1'b0;
      pend        <= 1'b0;
      wr_q        <= 1'b0;
      mem_a       <= IDLE_ADDR;
      mem_dout    <= '0;
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;
      bus.if_data <= '0;
      bus.ls_rdata <= '0;
    end else if (flush_hit) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      mem_a   <= IDLE_ADDR;
      issuing <= 1'b0;
      pend    <= 1'b0;
      cnt     <= '0;
    end else if (!rdy) begin
      // Bytes in flight are lost; park the first unaccepted address for the resume cycle.
      if (state == S_READ) begin
        pend    <= 1'b0;
        issuing <= 1'b1;
        iss     <= cnt;
        mem_a   <= base + ADDR_WIDTH'(cnt);
      end
    end else begin
      bus.if_done <= 1'b0;
      bus.ls_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.ls_req) begin
            port   <= PORT_LS;
            base   <= bus.ls_addr;
            n      <= size_bytes(bus.ls_size);
            wdata  <= bus.ls_wdata;
            buffer <= '0;
            cnt    <= '0;
            iss    <= '0;
            pend   <= 1'b0;
            mem_a  <= bus.ls_addr;
            if (bus.ls_wr) begin
              state    <= S_WRITE;
              wr_q     <= 1'b1;
              mem_dout <= bus.ls_wdata[7:0];
            end else begin
              state   <= S_READ;
              issuing <= 1'b1;
            end
          end else if (bus.if_req) begin
            port    <= PORT_IF;
            base    <= bus.if_addr;
            n       <= 3'd4;
            buffer  <= '0;
            cnt     <= '0;
            iss     <= '0;
            pend    <= 1'b0;
            issuing <= 1'b1;
            mem_a   <= bus.if_addr;
            state   <= S_READ;
          end
        end

        S_WRITE: begin
          if (cnt == last) begin
            state       <= S_DONE;
            wr_q        <= 1'b0;
            mem_a       <= IDLE_ADDR;
            bus.ls_done <= 1'b1;
          end else begin
            cnt      <= cnt_inc;
            mem_a    <= base + ADDR_WIDTH'(cnt_inc);
            mem_dout <= wdata[{cnt_inc[1:0], 3'b000} +: 8];
          end
        end

        S_READ: begin
          if (pend) begin
            buffer <= rd_word;
            cnt    <= cnt_inc;
          end
          if (pend && cnt == last) begin
            state   <= S_DONE;
            issuing <= 1'b0;
            pend    <= 1'b0;
            mem_a   <= IDLE_ADDR;
            if (port == PORT_IF) begin
              bus.if_done <= 1'b1;
              bus.if_data <= rd_word;
            end else begin
              bus.ls_done  <= 1'b1;
              bus.ls_rdata <= rd_word;
            end
          end else begin
            pend <= issuing;
            // Once the last byte is issued the bus returns to the idle address.
            if (issuing && iss != last) begin
              iss   <= iss_inc;
              mem_a <= base + ADDR_WIDTH'(iss_inc);
            end else begin
              issuing <= 1'b0;
              mem_a   <= IDLE_ADDR;
            end
          end
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-wide RAM/IO bus model, table-driven
// transfers with a done-pulse scoreboard, plus arbitration/stall/flush/reset sequences.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl_if #(.ADDR_WIDTH(32)) bus ();

  mem_ctrl #(.ADDR_WIDTH(32), .IDLE_ADDR(32'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .mem_a    (mem_a),
    .mem_wr   (mem_wr),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Bus model: registered byte read, writes land at the edge, IO window returns io_byte.
  logic [7:0]  ram [0:65535];
  logic [7:0]  io_byte;
  int          io_reads;
  bit          loaded = 1'b0;
  logic [39:0] wlog [$];
  logic [31:0] rlog [$];

  function automatic bit in_io(input logic [31:0] a);
    return (a >= IO_BASE) && (a < IO_BASE + 32'h0001_0000);
  endfunction

  always @(posedge clk) begin
    if (!loaded) begin
      loaded <= 1'b1;
      ram[16'h0100] <= 8'h13; ram[16'h0101] <= 8'h05; ram[16'h0102] <= 8'h00; ram[16'h0103] <= 8'h00;
      ram[16'h0200] <= 8'h93; ram[16'h0201] <= 8'h00; ram[16'h0202] <= 8'h10; ram[16'h0203] <= 8'h00;
      ram[16'h2000] <= 8'h11; ram[16'h2001] <= 8'h22; ram[16'h2002] <= 8'h01; ram[16'h2003] <= 8'h02;
      ram[16'h2004] <= 8'h55; ram[16'h2011] <= 8'h77; ram[16'h2024] <= 8'h66;
      ram[16'h2040] <= 8'h99; ram[16'h2041] <= 8'h99; ram[16'h2042] <= 8'h99; ram[16'h2043] <= 8'h99;
    end
    if (rdy) begin
      if (mem_wr) begin
        if (!in_io(mem_a)) ram[mem_a[15:0]] <= mem_dout;
        wlog.push_back({mem_a, mem_dout});
      end else begin
        if (in_io(mem_a)) begin
          mem_din <= io_byte;
          io_reads++;
        end else begin
          mem_din <= ram[mem_a[15:0]];
        end
        if (mem_a != 32'h0) rlog.push_back(mem_a);
      end
    end else begin
      mem_din <= 8'hEE;
    end
  end

  typedef struct {
    bit          ls;
    bit          chk;
    logic [31:0] data;
  } sb_t;
  sb_t sbq [$];

  always @(negedge clk) begin : sb_mon
    sb_t e;
    if (!rst && (bus.if_done || bus.ls_done)) begin
      if (sbq.size() == 0) begin
        check("unexpected done", 32'({bus.if_done, bus.ls_done}), 32'd0);
      end else begin
        e = sbq.pop_front();
        check("done port", 32'({bus.if_done, bus.ls_done}), e.ls ? 32'd1 : 32'd2);
        if (e.chk) check("done data", e.ls ? bus.ls_rdata : bus.if_data, e.data);
      end
    end
  end

  task automatic do_txn(input bit ls, input bit wr, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp, input int exp_lat, input string name);
    int k;
    bit seen;
    @(negedge clk);
    sbq.push_back('{ls: ls, chk: (!ls || !wr), data: exp});
    if (ls) begin
      bus.ls_req = 1'b1; bus.ls_wr = wr; bus.ls_size = sz;
      bus.ls_addr = addr; bus.ls_wdata = wd;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (ls ? bus.ls_done : bus.if_done) seen = 1'b1;
    end
    bus.ls_req = 1'b0;
    bus.if_req = 1'b0;
    check({name, " latency"}, 32'(k), 32'(exp_lat));
  endtask

  typedef struct {
    bit          ls;
    bit          wr;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp;
    int          lat;
  } vec_t;
  vec_t vecs [11];

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    int k, ls_k, if_k;
    bit seen;

    rst = 1'b1; rdy = 1'b1; io_byte = 8'h41; io_reads = 0;
    bus.if_req = 1'b0; bus.if_addr = '0; bus.flush = 1'b0;
    bus.ls_req = 1'b0; bus.ls_wr = 1'b0; bus.ls_size = 2'd0;
    bus.ls_addr = '0; bus.ls_wdata = '0;

    vecs[0]  = '{1, 0, 2'd2, 32'h0000_2000, 32'h0,         32'hCCDD_2211, 6};
    vecs[1]  = '{1, 0, 2'd0, 32'h0000_2004, 32'h0,         32'h0000_0055, 3};
    vecs[2]  = '{1, 1, 2'd0, 32'h0000_2010, 32'h1234_56F0, 32'h0,         2};
    vecs[3]  = '{1, 0, 2'd1, 32'h0000_2010, 32'h0,         32'h0000_77F0, 4};
    vecs[4]  = '{1, 1, 2'd2, 32'h0000_2020, 32'hDEAD_BEEF, 32'h0,         5};
    vecs[5]  = '{1, 0, 2'd3, 32'h0000_2020, 32'h0,         32'hDEAD_BEEF, 6};
    vecs[6]  = '{1, 0, 2'd0, 32'h0000_2023, 32'h0,         32'h0000_00DE, 3};
    vecs[7]  = '{1, 1, 2'd1, 32'hFFFF_FFFF, 32'h0000_BBAA, 32'h0,         3};
    vecs[8]  = '{1, 0, 2'd1, 32'hFFFF_FFFF, 32'h0,         32'h0000_BBAA, 4};
    vecs[9]  = '{0, 0, 2'd2, 32'h0000_0200, 32'h0,         32'h0010_0093, 6};
    vecs[10] = '{1, 0, 2'd2, 32'h0000_2021, 32'h0,         32'h66DE_ADBE, 6};

    repeat (3) @(negedge clk);
    check("reset mem_wr",   32'(mem_wr),      32'd0);
    check("reset mem_a",    mem_a,            32'h0);
    check("reset mem_dout", 32'(mem_dout),    32'd0);
    check("reset if_done",  32'(bus.if_done), 32'd0);
    check("reset ls_done",  32'(bus.ls_done), 32'd0);
    check("reset if_data",  bus.if_data,      32'd0);
    check("reset ls_rdata", bus.ls_rdata,     32'd0);
    rst = 1'b0;

    // Word fetch with address trace.
    rlog.delete();
    do_txn(0, 0, 2'd2, 32'h0000_0100, 32'h0, 32'h0000_0513, 6, "word fetch");
    check("fetch addr count", 32'(rlog.size()), 32'd4);
    for (int unsigned i = 0; i < 4 && i < rlog.size(); i++)
      check("fetch addr seq", rlog[i], 32'h100 + i);

    // Half store with write trace.
    wlog.delete();
    do_txn(1, 1, 2'd1, 32'h0000_2002, 32'hAABB_CCDD, 32'h0, 3, "half store");
    check("store write count", 32'(wlog.size()), 32'd2);
    if (wlog.size() >= 2) begin
      check("store byte0", wlog[0][39:8], 32'h2002);
      check("store data0", 32'(wlog[0][7:0]), 32'hDD);
      check("store byte1", wlog[1][39:8], 32'h2003);
      check("store data1", 32'(wlog[1][7:0]), 32'hCC);
    end

    // Simultaneous IF and LS: LS first, IF starts after LS DONE.
    @(negedge clk);
    io_reads = 0;
    sbq.push_back('{ls: 1, chk: 1, data: 32'h0000_0041});
    sbq.push_back('{ls: 0, chk: 1, data: 32'h0010_0093});
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0200;
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'd0; bus.ls_addr = IO_BASE;
    k = 0; ls_k = 0; if_k = 0;
    while (if_k == 0 && k < 40) begin
      @(negedge clk);
      k++;
      if (bus.ls_done) begin ls_k = k; bus.ls_req = 1'b0; end
      if (bus.if_done) begin if_k = k; bus.if_req = 1'b0; end
    end
    bus.if_req = 1'b0; bus.ls_req = 1'b0;
    check("arb ls_done cycle", 32'(ls_k), 32'd3);
    check("arb if_done cycle", 32'(if_k), 32'd10);
    check("arb io reads",      32'(io_reads), 32'd1);

    // rdy stall after byte 1 of a word load.
    @(negedge clk);
    rlog.delete();
    sbq.push_back('{ls: 1, chk: 1, data: 32'hCCDD_2211});
    bus.ls_req = 1'b1; bus.ls_wr = 1'b0; bus.ls_size = 2'd2; bus.ls_addr = 32'h0000_2000;
    k = 0; seen = 1'b0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 4) rdy = 1'b0;
      if (k == 7) rdy = 1'b1;
      if (k >= 4 && k <= 6) check("stall mem_wr", 32'(mem_wr), 32'd0);
      if (bus.ls_done) seen = 1'b1;
    end
    rdy = 1'b1;
    bus.ls_req = 1'b0;
    check("stall latency", 32'(k), 32'd10);
    check("stall issue count", 32'(rlog.size()), 32'd5);
    if (rlog.size() >= 5) begin
      check("stall reissue addr", rlog[3], 32'h2002);
      check("stall last addr",    rlog[4], 32'h2003);
    end

    // Flush during byte 2 of a fetch.
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0100;
    repeat (3) @(negedge clk);
    check("flush byte2 addr", mem_a, 32'h102);
    bus.flush = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    bus.flush = 1'b0;
    check("flush mem_a",  mem_a, 32'h0);
    check("flush mem_wr", 32'(mem_wr), 32'd0);
    check("flush state",  32'(dut.state), 32'(S_IDLE));
    repeat (4) @(negedge clk);
    do_txn(0, 0, 2'd2, 32'h0000_0200, 32'h0, 32'h0010_0093, 6, "post-flush fetch");

    for (int unsigned i = 0; i < 11; i++)
      do_txn(vecs[i].ls, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd,
             vecs[i].exp, vecs[i].lat, $sformatf("vec%0d", i));

    // Reset asserted between bytes 1 and 2 of a word store.
    @(negedge clk);
    bus.ls_req = 1'b1; bus.ls_wr = 1'b1; bus.ls_size = 2'd2;
    bus.ls_addr = 32'h0000_2040; bus.ls_wdata = 32'h0102_0304;
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1;
    check("pre-reset mem_wr", 32'(mem_wr), 32'd1);
    rst = 1'b1;
    #1;
    check("async reset mem_wr",  32'(mem_wr), 32'd0);
    check("async reset mem_a",   mem_a, 32'h0);
    check("async reset ls_done", 32'(bus.ls_done), 32'd0);
    bus.ls_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("idle after reset mem_a",  mem_a, 32'h0);
    check("idle after reset mem_wr", 32'(mem_wr), 32'd0);
    check("reset store byte0", 32'(ram[16'h2040]), 32'h04);
    check("reset store byte1", 32'(ram[16'h2041]), 32'h03);
    check("reset store byte2", 32'(ram[16'h2042]), 32'h99);
    check("reset store byte3", 32'(ram[16'h2043]), 32'h99);

    check("scoreboard drained", 32'(sbq.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
